simple_rx_checker: RTL and testbench
====================================

Name: simple_rx_checker

Overview:
- AXI-Stream sink directly downstream of simple_tx; consumes its generated packets and checks them against the expected header, body pattern and length.
- Maintains received-packet, error-packet and accepted-beat counters for host readout via the RO register bank.
- Reports a per-packet error code and a packet-done pulse.
- Pure sink: no master stream port.

Parameters:
- C_S_AXIS_DATA_WIDTH, 64, stream data width in bits.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width in bits.
- C_CHECK_PKT_SIZE, 2, expected beats per packet (header beat plus body beats), >=1.
- C_EXPECT_LEN, 16'h0040, expected tuser[15:0] byte-length field on the header beat.
- C_HDR_PATTERN, 64'haaaaaaaaaaaaaaaa, expected tdata on beat 0.
- C_BODY_PATTERN, 64'hffffffffffffffff, expected tdata on beats 1..N-1.
- C_CNT_WIDTH, 32, counter width.

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  reset.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  stream data.
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  metadata; [15:0] byte length.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  sink ready.
- s_axis_tlast  in  1  last beat of packet.
- enable  in  1  checker enable (RW register bit).
- rst_cntrs  in  1  counter clear, level-sensitive (RW register bit).
- rx_count  out  C_CNT_WIDTH  packets completed.
- err_count  out  C_CNT_WIDTH  packets with any error.
- beat_count  out  C_CNT_WIDTH  total beats accepted.
- last_err_code  out  3  error flags of the most recent packet.
- pkt_done  out  1  one-cycle pulse per completed packet.
- busy  out  1  high while inside a packet (state IN_PKT).

Behaviour:
- Reset (already decided): one clock, axi_aclk; reset is synchronous and active-low, axi_aresetn.
- Reset effect: state=IDLE; beat index=0; per-packet flags=0; all counters=0; last_err_code=0; pkt_done=0; busy=0.
- s_axis_tready = enable_r, where enable_r is enable registered once; during reset enable_r=0.
- Accept: a beat is accepted when s_axis_tvalid & s_axis_tready.
- State machine:
  - IDLE: on accept with tlast=0 go to IN_PKT; with tlast=1 finish the packet and stay in IDLE.
  - IN_PKT: on accepting a tlast beat, finish the packet and go to IDLE.
- Beat index: 16-bit, 0 on the first beat, +1 per accepted beat, saturates at 16'hFFFF.
- flag[0] header error, set on beat 0 if tdata!=C_HDR_PATTERN, tuser[15:0]!=C_EXPECT_LEN, or tstrb not all ones.
- flag[1] body error, set on any beat index>=1 with tdata!=C_BODY_PATTERN or tstrb not all ones.
- flag[2] length error, set if:
  - tlast arrives at beat index != C_CHECK_PKT_SIZE-1, or
  - a beat at index C_CHECK_PKT_SIZE-1 arrives without tlast.
  - After a length error the checker keeps consuming until tlast; no resync.
- Flags are sticky within a packet and evaluated on the tlast beat together with that beat's own checks.
- Packet finish, registered; visible the cycle after the tlast beat:
  - rx_count+1.
  - err_count+1 if any flag set.
  - last_err_code <= flags.
  - pkt_done=1 for exactly one cycle.
  - Flags and beat index cleared for the next packet.
- beat_count +1 per accepted beat.
- Counter width: all counters wrap modulo 2^C_CNT_WIDTH.
- rst_cntrs=1: rx_count, err_count and beat_count held at 0; clear wins over a simultaneous increment. State, flags and last_err_code are unaffected.
- enable deasserted mid-packet: tready drops the following cycle; state, index and flags hold; checking resumes on re-enable.
- Reset mid-packet: packet discarded with no count and no pkt_done; the next beat after reset is treated as beat 0.
- Back-to-back packets: a tlast beat followed immediately by the next packet's beat 0 is legal; full throughput, one beat per cycle.

Test Plan:
- Reset, enable=1, send 3 back-to-back 2-beat packets (aaaa.., tuser 0x04800040; ffff.., tlast) -> rx_count=3, err_count=0, beat_count=6, last_err_code=0, three pkt_done pulses each 1 cycle after tlast.
- Header beat tdata=64'h0 -> last_err_code=3'b001, err_count=1; rx_count still increments.
- 3-beat packet (tlast on beat 2) -> last_err_code=3'b100; tlast on beat 0 -> 3'b100 with flag[0] clear if the header matches.
- Body beat tstrb=8'h0F plus header tuser len 0x0020 -> last_err_code=3'b011.
- tvalid held while enable toggles 1->0 mid-packet for 5 cycles -> tready low for 5 cycles, no beats lost, packet passes cleanly; rst_cntrs pulsed on the tlast-finish cycle -> counters read 0 afterwards.
- axi_aresetn asserted after beat 0, then a good packet sent -> rx_count=1, err_count=0; preload counter to 2^32-1 via force -> wraps to 0.

Source files
------------

// File: rtl/simple_rx_checker_if.sv
// AXI-Stream bundle between simple_tx and simple_rx_checker.
// The master drives payload and valid. The slave drives ready.
interface simple_rx_checker_if #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
);

  logic [C_S_AXIS_DATA_WIDTH-1:0]   tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] tstrb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  tuser;
  logic                             tvalid;
  logic                             tready;
  logic                             tlast;

  modport master (
    output tdata,
    output tstrb,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/simple_rx_checker.sv
// AXI-Stream sink that checks packets generated by simple_tx.
// Each packet is checked against a fixed header beat, a fixed body pattern and a fixed beat count.
// The block keeps packet, error and beat counters for host readout.
// It reports the error flags of the most recent packet and pulses pkt_done once per packet.
module simple_rx_checker #(
  parameter int unsigned                 C_S_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned                 C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned                 C_CHECK_PKT_SIZE     = 2,
  parameter logic [15:0]                 C_EXPECT_LEN         = 16'h0040,
  parameter logic [C_S_AXIS_DATA_WIDTH-1:0] C_HDR_PATTERN     = 64'haaaaaaaaaaaaaaaa,
  parameter logic [C_S_AXIS_DATA_WIDTH-1:0] C_BODY_PATTERN    = 64'hffffffffffffffff,
  parameter int unsigned                 C_CNT_WIDTH          = 32
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,

  simple_rx_checker_if.slave     s_axis,

  input  logic                   enable,
  input  logic                   rst_cntrs,

  output logic [C_CNT_WIDTH-1:0] rx_count,
  output logic [C_CNT_WIDTH-1:0] err_count,
  output logic [C_CNT_WIDTH-1:0] beat_count,
  output logic [2:0]             last_err_code,
  output logic                   pkt_done,
  output logic                   busy
);

  localparam int unsigned StrbWidth = C_S_AXIS_DATA_WIDTH / 8;

  // Beat index at which tlast is expected.
  localparam logic [15:0] LastIdx = 16'(C_CHECK_PKT_SIZE - 1);

  localparam logic [C_CNT_WIDTH-1:0] CntOne = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  // Packet state encoding.
  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StInPkt = 1'b1;

  // Bit positions inside the per-packet flag vector.
  localparam int unsigned FlagHdr  = 0;
  localparam int unsigned FlagBody = 1;
  localparam int unsigned FlagLen  = 2;

  logic                   enable_q;
  logic [0:0]             state_q, state_d;
  logic [15:0]            beat_idx_q, beat_idx_d;
  logic [2:0]             flags_q, flags_d;
  logic [C_CNT_WIDTH-1:0] rx_count_q, rx_count_d;
  logic [C_CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [C_CNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [2:0]             last_err_code_q, last_err_code_d;
  logic                   pkt_done_q, pkt_done_d;

  logic                   accept;
  logic                   finish;
  logic                   strb_full;
  logic                   is_hdr_beat;
  logic                   at_last_idx;
  logic                   hdr_err;
  logic                   body_err;
  logic                   len_err;
  logic [2:0]             flags_acc;

  // The upper tuser bits carry metadata this checker does not inspect.
  logic unused_tuser;
  assign unused_tuser = ^s_axis.tuser[C_S_AXIS_TUSER_WIDTH-1:16];

  // Ready is the registered enable, so it follows enable one cycle later.
  assign s_axis.tready = enable_q;
  assign accept        = s_axis.tvalid & enable_q;
  assign finish        = accept & s_axis.tlast;

  // Register the enable bit. It is forced low during reset.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable;
    end
  end

  // Run the checks on the current beat and merge them with the sticky flags of the packet.
  always_comb begin
    strb_full   = &s_axis.tstrb;
    is_hdr_beat = (beat_idx_q == 16'h0000);
    at_last_idx = (beat_idx_q == LastIdx);

    hdr_err  = is_hdr_beat &
               ((s_axis.tdata != C_HDR_PATTERN) ||
                (s_axis.tuser[15:0] != C_EXPECT_LEN) ||
                !strb_full);
    body_err = !is_hdr_beat & ((s_axis.tdata != C_BODY_PATTERN) || !strb_full);

    // An error is raised both for an early tlast and for a tlast missing on the final beat.
    len_err  = s_axis.tlast ? !at_last_idx : at_last_idx;

    flags_acc           = flags_q;
    flags_acc[FlagHdr]  = flags_q[FlagHdr]  | hdr_err;
    flags_acc[FlagBody] = flags_q[FlagBody] | body_err;
    flags_acc[FlagLen]  = flags_q[FlagLen]  | len_err;
  end

  // Next-state logic for the packet FSM, the beat index and the flags.
  always_comb begin
    state_d         = state_q;
    beat_idx_d      = beat_idx_q;
    flags_d         = flags_q;
    last_err_code_d = last_err_code_q;
    pkt_done_d      = 1'b0;

    if (finish) begin
      // The packet is closed. Clear the per-packet state so the next beat is beat 0.
      state_d         = StIdle;
      beat_idx_d      = 16'h0000;
      flags_d         = 3'b000;
      last_err_code_d = flags_acc;
      pkt_done_d      = 1'b1;
    end else if (accept) begin
      state_d    = StInPkt;
      flags_d    = flags_acc;
      beat_idx_d = (beat_idx_q == 16'hFFFF) ? beat_idx_q : beat_idx_q + 16'd1;
    end
  end

  // Next-state logic for the counters. rst_cntrs holds them at zero and overrides any increment.
  always_comb begin
    rx_count_d   = rx_count_q;
    err_count_d  = err_count_q;
    beat_count_d = beat_count_q;

    if (rst_cntrs) begin
      rx_count_d   = '0;
      err_count_d  = '0;
      beat_count_d = '0;
    end else begin
      if (accept) begin
        beat_count_d = beat_count_q + CntOne;
      end
      if (finish) begin
        rx_count_d = rx_count_q + CntOne;
        if (|flags_acc) begin
          err_count_d = err_count_q + CntOne;
        end
      end
    end
  end

  // Packet-tracking state. A reset discards any packet that is still in progress.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q         <= StIdle;
      beat_idx_q      <= 16'h0000;
      flags_q         <= 3'b000;
      last_err_code_q <= 3'b000;
      pkt_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_idx_q      <= beat_idx_d;
      flags_q         <= flags_d;
      last_err_code_q <= last_err_code_d;
      pkt_done_q      <= pkt_done_d;
    end
  end

  // Host-visible counters. They wrap modulo 2^C_CNT_WIDTH.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      rx_count_q   <= '0;
      err_count_q  <= '0;
      beat_count_q <= '0;
    end else begin
      rx_count_q   <= rx_count_d;
      err_count_q  <= err_count_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign rx_count      = rx_count_q;
  assign err_count     = err_count_q;
  assign beat_count    = beat_count_q;
  assign last_err_code = last_err_code_q;
  assign pkt_done      = pkt_done_q;
  assign busy          = (state_q == StInPkt);

  // StrbWidth documents the strobe sizing used by the interface.
  logic unused_strb_width;
  assign unused_strb_width = (StrbWidth == 0);

endmodule

// File: tb/tb_simple_rx_checker.sv
// Self-checking bench for simple_rx_checker.
// The expected error code of each packet is queued when its tlast beat is accepted.
// A monitor pops the queue on every pkt_done pulse and compares.
module tb_simple_rx_checker;

  localparam int unsigned DW  = 64;
  localparam int unsigned UW  = 128;
  localparam int unsigned PKT = 2;

  localparam logic [63:0]  HDR  = 64'haaaaaaaaaaaaaaaa;
  localparam logic [63:0]  BODY = 64'hffffffffffffffff;
  localparam logic [127:0] GOOD = 128'h0000_0000_0000_0000_0000_0000_0480_0040;
  localparam logic [127:0] BADL = 128'h0000_0000_0000_0000_0000_0000_0480_0020;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn;
  logic        enable;
  logic        rst_cntrs;
  logic [31:0] rx_count;
  logic [31:0] err_count;
  logic [31:0] beat_count;
  logic [2:0]  last_err_code;
  logic        pkt_done;
  logic        busy;

  always #5 axi_aclk = ~axi_aclk;

  simple_rx_checker_if #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW)
  ) s_axis ();

  simple_rx_checker dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .s_axis        (s_axis),
    .enable        (enable),
    .rst_cntrs     (rst_cntrs),
    .rx_count      (rx_count),
    .err_count     (err_count),
    .beat_count    (beat_count),
    .last_err_code (last_err_code),
    .pkt_done      (pkt_done),
    .busy          (busy)
  );

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  exp_code;

  // Reference model state.
  int          m_idx;
  logic [2:0]  m_flags;
  logic [31:0] m_rx;
  logic [31:0] m_err;
  logic [31:0] m_beats;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check_val({tag, "_rx"},    rx_count,   m_rx);
    check_val({tag, "_err"},   err_count,  m_err);
    check_val({tag, "_beats"}, beat_count, m_beats);
  endtask

  // Pop one expected code per pkt_done pulse. A pulse with nothing queued is an error.
  always @(negedge axi_aclk) begin
    if (axi_aresetn === 1'b1 && pkt_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_done", 1, 0);
      end else begin
        exp_code = exp_q.pop_front();
        check_val("err_code", last_err_code, exp_code);
      end
    end
  end

  // Hold reset for three cycles and check the reset values. Call this at posedge+1.
  task automatic do_reset();
    axi_aresetn = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    repeat (3) @(posedge axi_aclk);
    #1;
    check_val("rst_rx",       rx_count,      0);
    check_val("rst_err",      err_count,     0);
    check_val("rst_beats",    beat_count,    0);
    check_val("rst_code",     last_err_code, 0);
    check_val("rst_done",     pkt_done,      0);
    check_val("rst_busy",     busy,          0);
    check_val("rst_tready",   s_axis.tready, 0);
    axi_aresetn = 1'b1;
    m_idx = 0; m_flags = 3'b000; m_rx = '0; m_err = '0; m_beats = '0;
    exp_q.delete();
  endtask

  // Present one beat and wait for it to be accepted. Call this at posedge+1. Returns at posedge+1.
  task automatic send_beat(input logic [63:0] data, input logic [7:0] strb,
                           input logic [127:0] user, input logic last);
    int         budget;
    logic       h, b, l;
    logic [2:0] f;
    s_axis.tdata  = data;
    s_axis.tstrb  = strb;
    s_axis.tuser  = user;
    s_axis.tlast  = last;
    s_axis.tvalid = 1'b1;
    budget = 0;
    while (s_axis.tready !== 1'b1 && budget < 50) begin
      @(posedge axi_aclk);
      #1;
      budget++;
    end
    if (s_axis.tready !== 1'b1) begin
      check_val("tready_timeout", 0, 1);
      s_axis.tvalid = 1'b0;
      return;
    end
    @(posedge axi_aclk);
    #1;
    h = (m_idx == 0) && (data != HDR || user[15:0] != 16'h0040 || strb != 8'hFF);
    b = (m_idx != 0) && (data != BODY || strb != 8'hFF);
    l = last ? (m_idx != PKT - 1) : (m_idx == PKT - 1);
    f = m_flags | {l, b, h};
    m_beats = m_beats + 1;
    if (last) begin
      exp_q.push_back(f);
      m_rx = m_rx + 1;
      if (f != 3'b000) m_err = m_err + 1;
      m_idx = 0;
      m_flags = 3'b000;
      check_val("done_latency", pkt_done, 1);
    end else begin
      m_idx++;
      m_flags = f;
    end
  endtask

  task automatic idle();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    @(posedge axi_aclk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    axi_aresetn   = 1'b0;
    enable        = 1'b1;
    rst_cntrs     = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tstrb  = '0;
    s_axis.tuser  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    do_reset();

    // Three good packets sent back to back.
    for (int i = 0; i < 3; i++) begin
      send_beat(HDR, 8'hFF, GOOD, 1'b0);
      if (i == 0) check_val("busy_in_pkt", busy, 1);
      send_beat(BODY, 8'hFF, GOOD, 1'b1);
    end
    idle();
    check_val("done_pulse_end", pkt_done, 0);
    check_val("busy_idle", busy, 0);
    check_val("good_rx", rx_count, 3);
    check_val("good_beats", beat_count, 6);
    check_val("good_code", last_err_code, 3'b000);
    check_val("q_drained", exp_q.size(), 0);
    check_counters("good");

    // Header beat with tdata equal to zero.
    send_beat(64'h0, 8'hFF, GOOD, 1'b0);
    send_beat(BODY, 8'hFF, GOOD, 1'b1);
    idle();
    check_val("hdr_code", last_err_code, 3'b001);
    check_counters("hdr");

    // Packet of three beats.
    send_beat(HDR, 8'hFF, GOOD, 1'b0);
    send_beat(BODY, 8'hFF, GOOD, 1'b0);
    send_beat(BODY, 8'hFF, GOOD, 1'b1);
    idle();
    check_val("long_code", last_err_code, 3'b100);

    // Packet of one beat, with a correct header.
    send_beat(HDR, 8'hFF, GOOD, 1'b1);
    idle();
    check_val("short_code", last_err_code, 3'b100);

    // Wrong length in the header, and a body strobe that is not full.
    send_beat(HDR, 8'hFF, BADL, 1'b0);
    send_beat(BODY, 8'h0F, GOOD, 1'b1);
    idle();
    check_val("hb_code", last_err_code, 3'b011);
    check_counters("errs");

    // Drop enable in the middle of a packet for five ready-low cycles.
    send_beat(HDR, 8'hFF, GOOD, 1'b0);
    s_axis.tvalid = 1'b0;
    enable = 1'b0;
    @(posedge axi_aclk);
    #1;
    s_axis.tdata  = BODY;
    s_axis.tstrb  = 8'hFF;
    s_axis.tuser  = GOOD;
    s_axis.tlast  = 1'b1;
    s_axis.tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_val("stall_tready", s_axis.tready, 0);
      if (i == 4) enable = 1'b1;
      @(posedge axi_aclk);
      #1;
    end
    check_val("stall_beats", beat_count, m_beats);
    check_val("stall_busy", busy, 1);
    send_beat(BODY, 8'hFF, GOOD, 1'b1);
    idle();
    check_val("stall_code", last_err_code, 3'b000);
    check_counters("stall");

    // Pulse rst_cntrs on the cycle that finishes the packet.
    send_beat(HDR, 8'hFF, GOOD, 1'b0);
    rst_cntrs = 1'b1;
    send_beat(BODY, 8'hFF, GOOD, 1'b1);
    rst_cntrs = 1'b0;
    m_rx = '0; m_err = '0; m_beats = '0;
    idle();
    check_counters("clr");

    // Reset in the middle of a packet. The packet is discarded.
    send_beat(HDR, 8'hFF, GOOD, 1'b0);
    do_reset();
    send_beat(HDR, 8'hFF, GOOD, 1'b0);
    send_beat(BODY, 8'hFF, GOOD, 1'b1);
    idle();
    check_val("post_rst_rx", rx_count, 1);
    check_val("post_rst_err", err_count, 0);

    // Preload rx_count to all ones and check that it wraps to zero.
    force dut.rx_count_q = 32'hFFFF_FFFF;
    @(posedge axi_aclk);
    #1;
    release dut.rx_count_q;
    m_rx = 32'hFFFF_FFFF;
    send_beat(HDR, 8'hFF, GOOD, 1'b0);
    send_beat(BODY, 8'hFF, GOOD, 1'b1);
    idle();
    check_val("wrap_rx", rx_count, 0);
    check_counters("wrap");

    idle();
    check_val("final_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
